instruction_fetch_queue: RTL and testbench
==========================================

# instruction_fetch_queue

Parametrised fetch stage that owns the program counter, reads a combinational instruction memory, and buffers fetched {PC, instruction} pairs in a FIFO for the decode stage. It adds backpressure, branch/jump redirect with queue flush, and PC wrap-around to the plain PC-plus-instruction-memory pair. It sits between the instruction memory and decode in the datapath.

## Interface
- XLEN, 32, PC and instruction width in bits.
- RESET_VECTOR, 32'h00000000, PC loaded on reset; bits [1:0] must be 0.
- DEPTH, 4, FIFO entries; power of two, ≥2.

- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- redirect_valid  input  1  load new PC and flush the queue this cycle.
- redirect_pc  input  XLEN  redirect target.
- imem_en  output  1  fetch accepted this cycle.
- imem_addr  output  XLEN  fetch address, equal to fetch_pc.
- imem_rdata  input  XLEN  instruction at imem_addr, valid in the same cycle.
- out_valid  output  1  head entry available.
- out_ready  input  1  decode consumes the head entry.
- out_pc  output  XLEN  PC of the head entry.
- out_instr  output  XLEN  instruction of the head entry.
- count  output  $clog2(DEPTH)+1  occupied entries.
- fault  output  1  misaligned redirect flag; see Configuration.

## Operation
- State: fetch_pc register, DEPTH×(2·XLEN) storage, rd_ptr/wr_ptr ($clog2(DEPTH) bits, natural wrap), count register, halted flag.
- imem_addr = fetch_pc, combinational.
- imem_en = (count < DEPTH) && !halted && !redirect_valid && !reset.
- Push: when imem_en is high, {fetch_pc, imem_rdata} is written at wr_ptr, wr_ptr++ and fetch_pc ← fetch_pc + 4 (mod 2^XLEN; 32'hFFFFFFFC wraps to 0).
- Pop: when out_valid && out_ready && !redirect_valid, rd_ptr++.
- count: +1 on push only, −1 on pop only, unchanged on push+pop.
- out_valid = (count != 0). out_pc/out_instr are read combinationally at rd_ptr. Their value is don't-care when out_valid is 0.
- Full (count == DEPTH): no fetch. A pop in that cycle frees a slot that is refilled in the next cycle, not the same one.
- Redirect: count, rd_ptr and wr_ptr are cleared to 0, and fetch_pc ← target. A pop in the same cycle is discarded. No push occurs.
- Priority: reset > redirect > push/pop.

## Timing
- Reset values: fetch_pc = RESET_VECTOR, count = 0, out_valid = 0, fault = 0, halted = 0, imem_en = 0 while reset is high. out_pc/out_instr are undefined.
- Reset mid-operation discards all entries, the same as power-up.
- First fetch occurs in the first cycle after reset deasserts. out_valid rises after the next edge, giving 1-cycle fetch-to-decode latency.
- Steady state with out_ready held at 1: one instruction per cycle, with count at 1.
- Redirect asserted in cycle N: out_valid = 0 in N+1, and the target is fetched in N+1. The target appears at the output in N+2.
- Back-to-back redirects: the last one wins and every redirect flushes.

## Configuration
- IFETCH_MISALIGN_CHECK_EN defined:
  - A redirect with redirect_pc[1:0] != 0 loads fetch_pc unmodified and sets fault = 1 and halted = 1 from the next cycle.
  - While halted, imem_en = 0. The queue stays empty.
  - fault and halted clear on reset or on the next aligned redirect.
- IFETCH_MISALIGN_CHECK_EN undefined:
  - fetch_pc loads {redirect_pc[XLEN-1:2], 2'b00}.
  - fault is tied to 0.
  - halted is never set.

## Test plan
- Reset with RESET_VECTOR = 0 and out_ready = 1 for 8 cycles -> out_pc = 0x00, 0x04 … 0x1C in consecutive cycles, each out_instr matching memory at that address, and count ≤ 1 throughout.
- out_ready = 0 for 10 cycles -> count saturates at 4 and imem_en drops. Then out_ready = 1 -> entries 0x00, 0x04, 0x08, 0x0C drain in order, with no gap and no duplicate.
- With 3 entries queued, redirect_valid = 1 and redirect_pc = 0x40 together with out_ready = 1 -> count = 0 next cycle, and the next out_pc is 0x40 two cycles after the redirect.
- Redirect to 0xFFFFFFF8 with out_ready = 1 -> output PCs are 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- Redirect to 0x22:
  - With IFETCH_MISALIGN_CHECK_EN: fault = 1 and imem_en = 0 until a redirect to 0x20 clears fault, after which fetch resumes at 0x20.
  - Without the macro: fault = 0 and fetch proceeds at 0x20.
- Assert reset for 1 cycle while full -> count = 0, out_valid = 0, and the next out_pc is RESET_VECTOR.

Source files
------------

// File: rtl/instruction_fetch_queue.sv
// Fetch stage: owns the PC, reads a combinational instruction memory and queues {PC, instr} pairs for decode.
// Optional misaligned-redirect trap is enabled by defining IFETCH_MISALIGN_CHECK_EN.
module instruction_fetch_queue #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              DEPTH        = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     redirect_valid,
    input  logic [XLEN-1:0]          redirect_pc,
    output logic                     imem_en,
    output logic [XLEN-1:0]          imem_addr,
    input  logic [XLEN-1:0]          imem_rdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_pc,
    output logic [XLEN-1:0]          out_instr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     fault
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_mem_pc    [DEPTH];
    logic [XLEN-1:0] r_mem_instr [DEPTH];
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;
    logic            r_halted;

    logic            w_push;
    logic            w_pop;
    logic [XLEN-1:0] w_redirect_pc;

`ifdef IFETCH_MISALIGN_CHECK_EN
    logic            w_misaligned;
    assign w_misaligned  = (redirect_pc[1:0] != 2'b00);
    assign w_redirect_pc = redirect_pc;
`else
    // Silently force word alignment when the trap is not built in.
    assign w_redirect_pc = redirect_pc & ~XLEN'(3);
`endif

    assign imem_en   = (r_count < CW'(DEPTH)) && !r_halted && !redirect_valid && !reset;
    assign imem_addr = r_fetch_pc;
    assign w_push    = imem_en;
    assign w_pop     = out_valid && out_ready && !redirect_valid;

    assign out_valid = (r_count != '0);
    assign out_pc    = r_mem_pc[r_rd_ptr];
    assign out_instr = r_mem_instr[r_rd_ptr];
    assign count     = r_count;
    assign fault     = r_halted;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc <= RESET_VECTOR;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_halted   <= 1'b0;
        end else if (redirect_valid) begin
            // Flush wins over any same-cycle pop; nothing is pushed.
            r_fetch_pc <= w_redirect_pc;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
`ifdef IFETCH_MISALIGN_CHECK_EN
            r_halted   <= w_misaligned;
`endif
        end else begin
            if (w_push) begin
                r_wr_ptr   <= r_wr_ptr + 1'b1;
                r_fetch_pc <= r_fetch_pc + XLEN'(4);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Queue storage carries no reset; validity is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pc[r_wr_ptr]    <= r_fetch_pc;
            r_mem_instr[r_wr_ptr] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Directed bench for instruction_fetch_queue: streaming, backpressure, redirect, PC wrap, misaligned redirect, reset.
module tb_instruction_fetch_queue;
    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [2:0]  count;
    logic        fault;

    int tests = 0;
    int fails = 0;

    instruction_fetch_queue #(.XLEN(32), .RESET_VECTOR(32'h0), .DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr),
        .count(count), .fault(fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_of(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    assign imem_rdata = mem_of(imem_addr);

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_pc"}, out_pc, pc);
        chk({tag, "_instr"}, out_instr, mem_of(pc));
    endtask

    initial begin
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
        cyc(); cyc();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_imem_en", 32'(imem_en), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);

        // Streaming with out_ready held high
        reset = 1'b0; #1;
        chk("first_en", 32'(imem_en), 32'd1);
        chk("first_addr", imem_addr, 32'h0);
        chk("first_valid", 32'(out_valid), 32'd0);
        for (int k = 0; k < 8; k++) begin
            cyc();
            chk_head("stream", 32'(4 * k));
            chk("stream_count", 32'(count), 32'd1);
        end

        // Backpressure after a fresh reset
        reset = 1'b1; out_ready = 1'b0;
        cyc();
        reset = 1'b0;
        for (int k = 0; k < 10; k++) cyc();
        chk("full_count", 32'(count), 32'd4);
        chk("full_en", 32'(imem_en), 32'd0);
        out_ready = 1'b1; #1;
        chk("full_pop_en", 32'(imem_en), 32'd0);
        chk_head("drain0", 32'h00);
        cyc(); chk_head("drain1", 32'h04);
        chk("drain_count", 32'(count), 32'd3);
        chk("refill_en", 32'(imem_en), 32'd1);
        cyc(); chk_head("drain2", 32'h08);
        cyc(); chk_head("drain3", 32'h0C);
        cyc(); chk_head("drain4", 32'h10);
        chk("pre_redir_count", 32'(count), 32'd3);

        // Redirect with 3 entries queued and a same-cycle pop
        redirect_valid = 1'b1; redirect_pc = 32'h40; #1;
        chk("redir_en", 32'(imem_en), 32'd0);
        cyc();
        redirect_valid = 1'b0; #1;
        chk("redir_count", 32'(count), 32'd0);
        chk("redir_valid", 32'(out_valid), 32'd0);
        chk("redir_addr", imem_addr, 32'h40);
        chk("redir_en2", 32'(imem_en), 32'd1);
        cyc(); chk_head("redir_head", 32'h40);

        // PC wrap-around
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        cyc();
        redirect_valid = 1'b0; #1;
        chk("wrap_valid", 32'(out_valid), 32'd0);
        cyc(); chk_head("wrap0", 32'hFFFF_FFF8);
        cyc(); chk_head("wrap1", 32'hFFFF_FFFC);
        cyc(); chk_head("wrap2", 32'h0000_0000);

        // Back-to-back redirects: last one wins
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        cyc();
        redirect_pc = 32'h200;
        cyc();
        redirect_valid = 1'b0; #1;
        chk("b2b_addr", imem_addr, 32'h200);
        chk("b2b_valid", 32'(out_valid), 32'd0);
        cyc(); chk_head("b2b_head", 32'h200);

        // Misaligned redirect
        redirect_valid = 1'b1; redirect_pc = 32'h22;
        cyc();
        redirect_valid = 1'b0; #1;
`ifdef IFETCH_MISALIGN_CHECK_EN
        chk("mis_fault", 32'(fault), 32'd1);
        chk("mis_en", 32'(imem_en), 32'd0);
        chk("mis_addr", imem_addr, 32'h22);
        cyc(); cyc();
        chk("mis_fault_hold", 32'(fault), 32'd1);
        chk("mis_count", 32'(count), 32'd0);
        chk("mis_en_hold", 32'(imem_en), 32'd0);
        redirect_valid = 1'b1; redirect_pc = 32'h20;
        cyc();
        redirect_valid = 1'b0; #1;
        chk("mis_clear", 32'(fault), 32'd0);
`else
        chk("mis_fault", 32'(fault), 32'd0);
`endif
        chk("mis_resume_addr", imem_addr, 32'h20);
        chk("mis_resume_en", 32'(imem_en), 32'd1);
        cyc(); chk_head("mis_head", 32'h20);

        // Reset for one cycle while full
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) cyc();
        chk("fill_count", 32'(count), 32'd4);
        reset = 1'b1;
        cyc();
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_en", 32'(imem_en), 32'd0);
        reset = 1'b0; out_ready = 1'b1; #1;
        chk("post_rst_addr", imem_addr, 32'h0);
        cyc(); chk_head("post_rst_head", 32'h0);
        chk("post_rst_count", 32'(count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
